// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared frame layout, egress FSM states and synchroniser helper
`timescale 1ns/1ps
package router_pkg;

  // Source address width; a frame is {src_adr[ADR_W-1:0], data[DW-1:0]},
  // so src_adr always sits at [DW+ADR_W-1:DW] above the payload.
  localparam int ADR_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } egress_state_t;

  // Next value of a 2-flop synchroniser chain: bit 0 samples the async input,
  // bit 1 is the synchronised output.
  function automatic logic [1:0] sync2_next(input logic [1:0] q, input logic d);
    return {q[0], d};
  endfunction

endpackage

// File: rtl/egress_fifo.sv
// rtl/egress_fifo.sv - frame FIFO with registered occupancy count
`timescale 1ns/1ps
module egress_fifo
  import router_pkg::*;
#(
  parameter int W     = 7,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [W-1:0]     wr_dat_i,
  input  logic             pop_i,
  output logic [W-1:0]     rd_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [DEPTH:0]   count_o
);

  localparam int SLOTS = 2 ** DEPTH;
  localparam logic [DEPTH-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH:0]   CNT_ONE  = 1;
  localparam logic [DEPTH:0]   CNT_FULL = (DEPTH + 1)'(SLOTS);

  logic [W-1:0]     mem_q [SLOTS];
  logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH:0]   count_q, count_d;
  logic             do_push, do_pop;

  // Full/empty come from the registered count only, so a pop in the same
  // cycle never opens room for a push.
  assign full_o   = (count_q == CNT_FULL);
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign rd_dat_o = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at 2**DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Frame storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/router_egress_port.sv
// rtl/router_egress_port.sv - buffered four-phase egress transmitter toward one device
`timescale 1ns/1ps
module router_egress_port
  import router_pkg::*;
#(
  parameter int DW    = 4,
  parameter int DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DW+ADR_W-1:0] in_dat,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DW+ADR_W-1:0] dat_o,
  output logic                validrx,
  input  logic                ackrx,
  output logic [DEPTH:0]      count_o,
  output logic                busy_o
);

  localparam int FW = DW + ADR_W;

  egress_state_t state_q, state_d;
  logic [1:0]    ack_sync_q;
  logic          ack_s;
  logic [FW-1:0] dat_q, dat_d;
  logic          validrx_q, busy_q;
  logic          pop;
  logic          fifo_full, fifo_empty;
  logic [FW-1:0] fifo_head;

  egress_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (in_valid),
    .wr_dat_i (in_dat),
    .pop_i    (pop),
    .rd_dat_o (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (count_o)
  );

  assign in_ready = !fifo_full;
  assign ack_s    = ack_sync_q[1];
  assign dat_o    = dat_q;
  assign validrx  = validrx_q;
  assign busy_o   = busy_q;

  // Bring the device acknowledge into the router clock domain.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ack_sync_q <= '0;
    else        ack_sync_q <= sync2_next(ack_sync_q, ackrx);
  end

  // Handshake sequencing: a new request only starts once the previous
  // acknowledge (or a stale one from before reset) has been seen low.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !ack_s) begin
          state_d = REQ;
          pop     = 1'b1;
          dat_d   = fifo_head;
        end
      end
      REQ:     if (ack_s)  state_d = REL;
      REL:     if (!ack_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State plus registered outputs decoded from the next state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      dat_q     <= '0;
      validrx_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dat_q     <= dat_d;
      validrx_q <= (state_d == REQ);
      busy_q    <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_router_egress_port.sv
// tb/tb_router_egress_port.sv - scoreboard bench for router_egress_port
`timescale 1ns/1ps
module tb_router_egress_port;

  localparam int DW    = 4;
  localparam int DEPTH = 2;
  localparam int FW    = DW + 3;

  logic             clk_i    = 1'b0;
  logic             dclk     = 1'b0;
  logic             rst_i    = 1'b0;
  logic [FW-1:0]    in_dat   = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [FW-1:0]    dat_o;
  logic             validrx;
  logic             ackrx;
  logic [DEPTH:0]   count_o;
  logic             busy_o;

  logic dev_auto   = 1'b0;
  logic ack_dev    = 1'b0;
  logic ack_manual = 1'b0;

  int checks    = 0;
  int failures  = 0;
  int delivered = 0;

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] held       = '0;
  logic          prev_valid = 1'b0;

  assign ackrx = dev_auto ? ack_dev : ack_manual;

  always #2.5 clk_i = ~clk_i;
  always #3.5 dclk  = ~dclk;

  router_egress_port #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .in_dat   (in_dat),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dat_o    (dat_o),
    .validrx  (validrx),
    .ackrx    (ackrx),
    .count_o  (count_o),
    .busy_o   (busy_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic push(input logic [FW-1:0] d, input bit accepted);
    in_dat   = d;
    in_valid = 1'b1;
    if (accepted) exp_q.push_back(d);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [FW-1:0] d);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick(1);
      n++;
    end
    chk("push_wait_ready", in_ready, 1);
    push(d, 1'b1);
  endtask

  task automatic handshake();
    int n;
    n = 0;
    while (!validrx && n < 40) begin tick(1); n++; end
    chk("hs_req", validrx, 1);
    ack_manual = 1'b1;
    n = 0;
    while (validrx && n < 40) begin tick(1); n++; end
    chk("hs_req_drop", validrx, 0);
    ack_manual = 1'b0;
    n = 0;
    while (busy_o && n < 40) begin tick(1); n++; end
    chk("hs_idle", busy_o, 0);
  endtask

  // Device model for the streaming test, clocked on its own unrelated clock.
  initial begin
    forever begin
      @(posedge dclk);
      #0.5;
      if (dev_auto) begin
        if (validrx && !ack_dev)      ack_dev = 1'b1;
        else if (!validrx && ack_dev) ack_dev = 1'b0;
      end
    end
  end

  // Monitor: each new request must carry the oldest outstanding frame, and
  // the frame must hold while the request stays up.
  initial begin
    logic [FW-1:0] e;
    forever begin
      @(posedge clk_i);
      #1;
      if (validrx && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame actual=%0h required=none", dat_o);
        end else begin
          e = exp_q.pop_front();
          chk("frame_order", dat_o, e);
          delivered++;
        end
        held = dat_o;
      end else if (validrx && prev_valid) begin
        chk("dat_stable", dat_o, held);
      end
      prev_valid = validrx;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;

    // Reset values, no clock edge yet.
    #1;
    chk("rst_validrx", validrx, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_in_ready", in_ready, 1);
    tick(2);
    rst_i = 1'b1;
    tick(2);

    // Single frame: request one cycle after the push edge.
    push(7'h56, 1'b1);
    chk("t1_count_after_push", count_o, 1);
    chk("t1_validrx_early", validrx, 0);
    tick(1);
    chk("t1_validrx", validrx, 1);
    chk("t1_dat", dat_o, 7'h56);
    chk("t1_count_popped", count_o, 0);
    chk("t1_busy", busy_o, 1);
    ack_manual = 1'b1;
    tick(2);
    chk("t1_validrx_m1", validrx, 1);
    tick(1);
    chk("t1_validrx_m2", validrx, 0);
    chk("t1_busy_rel", busy_o, 1);
    ack_manual = 1'b0;
    tick(2);
    chk("t1_busy_k1", busy_o, 1);
    tick(1);
    chk("t1_busy_k2", busy_o, 0);

    // Fill to full with the device silent.
    d0 = delivered;
    push(7'h11, 1'b1);
    chk("t2_count_a", count_o, 1);
    push(7'h12, 1'b1);
    chk("t2_count_b", count_o, 1);
    push(7'h13, 1'b1);
    push(7'h14, 1'b1);
    push(7'h15, 1'b1);
    chk("t2_count_full", count_o, 4);
    chk("t2_ready_full", in_ready, 0);
    push(7'h16, 1'b0);
    chk("t2_count_rejected", count_o, 4);
    chk("t2_dat_head", dat_o, 7'h11);
    repeat (5) handshake();
    chk("t2_delivered", delivered - d0, 5);
    chk("t2_count_empty", count_o, 0);
    chk("t2_ready_empty", in_ready, 1);

    // Streaming through a responding device on its own clock.
    dev_auto = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 12; i++) push_wait(FW'(8'h20 + i));
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 2000) begin tick(1); n++; end
    chk("t3_delivered", delivered - d0, 12);
    chk("t3_queue_empty", exp_q.size(), 0);
    chk("t3_idle", busy_o, 0);
    dev_auto = 1'b0;

    // Stale acknowledge through reset release.
    ack_manual = 1'b1;
    rst_i = 1'b0;
    tick(2);
    rst_i = 1'b1;
    tick(3);
    push(7'h3A, 1'b1);
    tick(4);
    chk("t4_validrx_held", validrx, 0);
    chk("t4_busy_held", busy_o, 0);
    chk("t4_count", count_o, 1);
    ack_manual = 1'b0;
    tick(2);
    chk("t4_validrx_k1", validrx, 0);
    tick(1);
    chk("t4_validrx_k2", validrx, 1);
    handshake();

    // Push and pop on the same edge at count 2.
    ack_manual = 1'b1;
    tick(3);
    push(7'h41, 1'b1);
    push(7'h42, 1'b1);
    chk("t5_count_pre", count_o, 2);
    chk("t5_busy_pre", busy_o, 0);
    ack_manual = 1'b0;
    tick(2);
    in_dat   = 7'h43;
    in_valid = 1'b1;
    exp_q.push_back(7'h43);
    tick(1);
    in_valid = 1'b0;
    chk("t5_count_same", count_o, 2);
    chk("t5_validrx", validrx, 1);

    // Reset mid-request with two frames buffered: no clock needed.
    rst_i = 1'b0;
    #0.5;
    chk("t6_validrx_async", validrx, 0);
    chk("t6_count_async", count_o, 0);
    chk("t6_busy_async", busy_o, 0);
    chk("t6_dat_async", dat_o, 0);
    chk("t6_ready_async", in_ready, 1);
    exp_q.delete();
    tick(2);
    rst_i = 1'b1;
    tick(10);
    chk("t6_no_resend", validrx, 0);
    chk("t6_count_after", count_o, 0);
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
